instr_readback_seq: RTL and testbench

// - Downstream read-side companion of the instruction register.
// - On a start pulse it sweeps read_pointer over a programmable address window, incrementing or decrementing.
// - Captures each returned instruction_word (opcode, operands, rezultat) into a small FIFO.
// - Presents captured words on a valid/ready stream to the consumer (scoreboard / writeback).

---
 rtl/instr_readback_seq.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_instr_readback_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_readback_seq.sv
// ---------------------------------------------------------------------------
// instr_readback_seq
//
// Read-side companion of the instruction register. A start pulse launches a
// sweep of read_pointer over an address window (incrementing or decrementing,
// wrapping mod 32). Each word returned by the instruction register is
// captured, together with the address it came from, into a small FIFO. The
// FIFO head is then presented on a valid/ready stream.
//
// instruction_word / out_word layout (131 bits):
//   [130:128] opc       3-bit opcode (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD)
//   [127:96]  op_a      signed 32-bit operand
//   [95:64]   op_b      signed 32-bit operand
//   [63:0]    rezultat  signed 64-bit result
//
// Optional feature: define INSTR_RDSEQ_CHECK_EN to recompute the result of
// every captured word and count mismatches in err_cnt (saturating, cleared
// by an accepted start). Without the macro err_cnt is tied to 0.
//
// Parameters:
//   RD_LATENCY  cycles from read_pointer update to valid instruction_word (1..4)
//   FIFO_DEPTH  output FIFO entries, power of 2, 2..16
//
// Ports:
//   clk               system clock, rising edge
//   reset_n           asynchronous active-low reset
//   start             1-cycle pulse, launches a sweep (ignored unless idle)
//   dir               0 = incrementing, 1 = decrementing addresses
//   start_addr[4:0]   first address of the sweep
//   count[5:0]        words to read, values above 32 clamp to 32
//   read_pointer[4:0] address driven to the instruction register
//   instruction_word  read data from the instruction register
//   out_valid         FIFO head valid
//   out_ready         consumer accepts head when out_valid & out_ready
//   out_addr[4:0]     address the head word was read from
//   out_word          captured instruction word at the head
//   busy              sweep in progress (ISSUE or DRAIN)
//   done              1-cycle pulse when a sweep completes
//   err_cnt[7:0]      result-check mismatch count
// ---------------------------------------------------------------------------
module instr_readback_seq #(
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         dir,
  input  logic [4:0]   start_addr,
  input  logic [5:0]   count,
  output logic [4:0]   read_pointer,
  input  logic [130:0] instruction_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   out_addr,
  output logic [130:0] out_word,
  output logic         busy,
  output logic         done,
  output logic [7:0]   err_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Sweep control
  logic       dir_reg;
  logic [4:0] addr_reg;
  logic [5:0] remaining_reg;
  logic [4:0] read_pointer_reg;

  // In-flight tracking: one tag per outstanding read, shifted once per cycle
  logic [RD_LATENCY-1:0]      pipe_vld_reg;
  logic [RD_LATENCY-1:0]      pipe_vld_next;
  logic [RD_LATENCY-1:0][4:0] pipe_addr_reg;
  logic [RD_LATENCY-1:0][4:0] pipe_addr_next;
  logic [2:0]                 inflight;

  // Output FIFO
  logic [130:0]     word_mem [FIFO_DEPTH];
  logic [4:0]       addr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] fifo_cnt_reg;

  logic       start_ok;
  logic [5:0] count_clamped;
  logic [5:0] occupancy;
  logic       issue_space;
  logic       issue_fire;
  logic       push;
  logic       pop;

  assign count_clamped = (count > 6'd32) ? 6'd32 : count;
  assign start_ok      = (state_reg == S_IDLE) && start;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + 3'(pipe_vld_reg[i]);
    end
  end

  // Only issue when every outstanding read is guaranteed a FIFO slot. A pop
  // in the same cycle is deliberately not credited, which keeps this path
  // independent of out_ready.
  assign occupancy   = 6'(fifo_cnt_reg) + 6'(inflight);
  assign issue_space = occupancy < 6'(FIFO_DEPTH);
  assign issue_fire  = (state_reg == S_ISSUE) && issue_space;

  // The oldest tag reaching the end of the pipe means instruction_word now
  // holds the data for that address.
  assign push = pipe_vld_reg[RD_LATENCY-1];
  assign pop  = out_valid && out_ready;

  // ------------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (count_clamped == 6'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (issue_fire && (remaining_reg == 6'd1)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (inflight == 3'd0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Address generation
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_reg          <= 1'b0;
      addr_reg         <= 5'd0;
      remaining_reg    <= 6'd0;
      read_pointer_reg <= 5'h1F;
    end else begin
      if (start_ok) begin
        dir_reg       <= dir;
        addr_reg      <= start_addr;
        remaining_reg <= count_clamped;
      end else if (issue_fire) begin
        read_pointer_reg <= addr_reg;
        // 5-bit arithmetic gives the 31<->0 wrap for free
        addr_reg         <= dir_reg ? (addr_reg - 5'd1) : (addr_reg + 5'd1);
        remaining_reg    <= remaining_reg - 6'd1;
      end
    end
  end

  assign read_pointer = read_pointer_reg;

  // ------------------------------------------------------------------------
  // In-flight pipe: stage 0 takes the tag of the read issued this cycle
  // ------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_vld_next[gi]  = issue_fire;
        assign pipe_addr_next[gi] = addr_reg;
      end else begin : g_tail
        assign pipe_vld_next[gi]  = pipe_vld_reg[gi-1];
        assign pipe_addr_next[gi] = pipe_addr_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld_reg  <= '0;
      pipe_addr_reg <= '0;
    end else begin
      pipe_vld_reg  <= pipe_vld_next;
      pipe_addr_reg <= pipe_addr_next;
    end
  end

  // ------------------------------------------------------------------------
  // Output FIFO
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_reg] <= instruction_word;
      addr_mem[wr_ptr_reg] <= pipe_addr_reg[RD_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // Head is gated to zero when empty so the outputs are clean after reset
  // and never expose stale storage.
  assign out_valid = (fifo_cnt_reg != '0);
  assign out_word  = out_valid ? word_mem[rd_ptr_reg] : '0;
  assign out_addr  = out_valid ? addr_mem[rd_ptr_reg] : '0;

  // ------------------------------------------------------------------------
  // Optional result checker on the captured word
  // ------------------------------------------------------------------------
`ifdef INSTR_RDSEQ_CHECK_EN
  logic [2:0]         chk_opc;
  logic signed [63:0] chk_a;
  logic signed [63:0] chk_b;
  logic signed [63:0] chk_res;
  logic signed [63:0] chk_exp;
  logic               chk_mismatch;
  logic [7:0]         err_cnt_reg;

  assign chk_opc = instruction_word[130:128];
  assign chk_a   = {{32{instruction_word[127]}}, instruction_word[127:96]};
  assign chk_b   = {{32{instruction_word[95]}}, instruction_word[95:64]};
  assign chk_res = instruction_word[63:0];

  always_comb begin
    chk_exp = '0;
    case (chk_opc)
      3'd0: chk_exp = '0;
      3'd1: chk_exp = chk_a;
      3'd2: chk_exp = chk_b;
      3'd3: chk_exp = chk_a + chk_b;
      3'd4: chk_exp = chk_a - chk_b;
      3'd5: chk_exp = chk_a * chk_b;
      3'd6: chk_exp = (chk_b == 64'sd0) ? 64'sd0 : (chk_a / chk_b);
      3'd7: chk_exp = (chk_b == 64'sd0) ? 64'sd0 : (chk_a % chk_b);
      default: chk_exp = '0;
    endcase
  end

  // Four-state compare so an X/Z result is also flagged in simulation
  assign chk_mismatch = push && (chk_res !== chk_exp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_reg <= 8'd0;
    end else if (start_ok) begin
      err_cnt_reg <= 8'd0;
    end else if (chk_mismatch && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_instr_readback_seq.sv
module tb_instr_readback_seq;

  localparam int RD_LAT = 1;
  localparam int DEPTH  = 4;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         dir;
  logic [4:0]   start_addr;
  logic [5:0]   count;
  logic [4:0]   read_pointer;
  logic [130:0] instruction_word;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_addr;
  logic [130:0] out_word;
  logic         busy;
  logic         done;
  logic [7:0]   err_cnt;

  instr_readback_seq #(.RD_LATENCY(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dir(dir),
    .start_addr(start_addr), .count(count), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_word(out_word),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction register model ----------------
  logic [130:0] imem [32];
  logic         bad  [32];

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign instruction_word = imem[read_pointer];
    end else begin : g_latn
      logic [4:0] rp_hist [4];
      always @(posedge clk) begin
        rp_hist[0] <= read_pointer;
        for (int i = 1; i < 4; i++) rp_hist[i] <= rp_hist[i-1];
      end
      assign instruction_word = imem[rp_hist[RD_LAT-2]];
    end
  endgenerate

  function automatic logic [63:0] ref_result(input logic [2:0] opc, input int a, input int b);
    longint la;
    longint lb;
    la = a;
    lb = b;
    case (opc)
      3'd0: return 64'd0;
      3'd1: return la;
      3'd2: return lb;
      3'd3: return la + lb;
      3'd4: return la - lb;
      3'd5: return la * lb;
      3'd6: return (lb == 0) ? 64'd0 : la / lb;
      default: return (lb == 0) ? 64'd0 : la % lb;
    endcase
  endfunction

  function automatic logic [130:0] make_word(input logic [2:0] opc, input int a, input int b,
                                             input logic corrupt);
    logic [63:0] r;
    r = ref_result(opc, a, b) + (corrupt ? 64'd1 : 64'd0);
    return {opc, a, b, r};
  endfunction

  task automatic fill_mem();
    logic [2:0] opc;
    int a;
    int b;
    logic c;
    for (int i = 0; i < 32; i++) begin
      opc = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 1) == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
      b   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 60)) - 30;
      c   = ($urandom_range(0, 3) == 0);
      imem[i] = make_word(opc, a, b, c);
      bad[i]  = c;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [135:0] exp_q [$];
  int n_pass  = 0;
  int n_total = 0;
  int done_seen = 0;
  int exp_err = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  always @(negedge clk) begin
    if (reset_n && done) done_seen++;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 136'(out_addr), 136'h1_0000);
      end else begin
        logic [135:0] e;
        e = exp_q.pop_front();
        chk("out_addr", 136'(out_addr), 136'(e[135:131]));
        chk("out_word", 136'(out_word), 136'(e[130:0]));
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue_start(input logic d, input logic [4:0] sa, input logic [5:0] cnt,
                             input logic expect_accept);
    int n;
    int e;
    logic [4:0] a;
    if (expect_accept) begin
      n = (cnt > 6'd32) ? 32 : int'(cnt);
      e = 0;
      for (int i = 0; i < n; i++) begin
        a = d ? (sa - 5'(i)) : (sa + 5'(i));
        exp_q.push_back({a, imem[a]});
        if (bad[a]) e++;
      end
`ifdef INSTR_RDSEQ_CHECK_EN
      exp_err = (e > 255) ? 255 : e;
`else
      exp_err = 0;
`endif
    end
    @(posedge clk);
    #1;
    dir = d; start_addr = sa; count = cnt; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_sweep(input int d0, input string nm);
    int k;
    k = 0;
    while (done_seen == d0 && k < 3000) begin
      @(negedge clk); #1; k++;
    end
    chk({nm, "_done_seen"}, 136'(done_seen), 136'(d0 + 1));
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk); #1; k++;
    end
    chk({nm, "_drained"}, 136'(exp_q.size()), 136'd0);
    @(negedge clk); #1;
    chk({nm, "_single_done"}, 136'(done_seen), 136'(d0 + 1));
    chk({nm, "_busy_low"}, 136'(busy), 136'd0);
    chk({nm, "_err_cnt"}, 136'(err_cnt), 136'(exp_err));
    $display("sweep %s finished, words checked so far %0d", nm, n_total);
  endtask

  task automatic run_sweep(input logic d, input logic [4:0] sa, input logic [5:0] cnt,
                           input string nm);
    int d0;
    d0 = done_seen;
    issue_start(d, sa, cnt, 1'b1);
    finish_sweep(d0, nm);
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_read_pointer"}, 136'(read_pointer), 136'h1F);
    chk({nm, "_out_valid"},    136'(out_valid),    136'd0);
    chk({nm, "_out_addr"},     136'(out_addr),     136'd0);
    chk({nm, "_out_word"},     136'(out_word),     136'd0);
    chk({nm, "_busy"},         136'(busy),         136'd0);
    chk({nm, "_done"},         136'(done),         136'd0);
    chk({nm, "_err_cnt"},      136'(err_cnt),      136'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    int k;
    logic [4:0] sa;
    reset_n = 1'b0; start = 1'b0; dir = 1'b0; start_addr = '0; count = '0;
    fill_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    // incrementing sweep
    ready_mode = 0;
    fill_mem();
    run_sweep(1'b0, 5'd0, 6'd3, "incr");

    // decrementing with wrap: 1,0,31,30
    fill_mem();
    run_sweep(1'b1, 5'd1, 6'd4, "decr_wrap");

    // backpressure: stalls once the FIFO plus in-flight reads fill up
    fill_mem();
    ready_mode = 2;
    sa = 5'($urandom_range(0, 31));
    d0 = done_seen;
    issue_start(1'b0, sa, 6'd10, 1'b1);
    repeat (30) @(posedge clk);
    @(negedge clk); #1;
    chk("bp_busy", 136'(busy), 136'd1);
    chk("bp_out_valid", 136'(out_valid), 136'd1);
    chk("bp_no_pop", 136'(exp_q.size()), 136'd10);
    chk("bp_stalled_pointer", 136'(read_pointer), 136'(5'(sa + 5'd3)));
    chk("bp_no_done", 136'(done_seen), 136'(d0));
    ready_mode = 0;
    finish_sweep(d0, "backpressure");

    // count == 0: done pulse only, no words
    fill_mem();
    d0 = done_seen;
    issue_start(1'b0, 5'd5, 6'd0, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    chk("zero_done", 136'(done_seen), 136'(d0 + 1));
    chk("zero_no_valid", 136'(out_valid), 136'd0);

    // count == 40 clamps to 32 words, random consumer
    fill_mem();
    ready_mode = 1;
    run_sweep(1'b0, 5'd7, 6'd40, "clamp40");

    // start while busy is ignored
    fill_mem();
    d0 = done_seen;
    issue_start(1'b1, 5'd20, 6'd12, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("restart_busy", 136'(busy), 136'd1);
    issue_start(1'b0, 5'd0, 6'd5, 1'b0);
    finish_sweep(d0, "restart_ignored");

    // reset mid-sweep after two words delivered
    fill_mem();
    ready_mode = 0;
    d0 = done_seen;
    issue_start(1'b0, 5'd10, 6'd20, 1'b1);
    k = 0;
    while (exp_q.size() > 18 && k < 200) begin
      @(negedge clk); #1; k++;
    end
    chk("mid_two_words", 136'(exp_q.size()), 136'd18);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_values("mid_reset");
    repeat (3) @(negedge clk);
    chk("mid_no_done", 136'(done_seen), 136'(d0));
    reset_n = 1'b1;
    fill_mem();
    run_sweep(1'b1, 5'd3, 6'd6, "after_reset");

    // randomized sweeps
    for (int s = 0; s < 8; s++) begin
      fill_mem();
      ready_mode = $urandom_range(0, 1);
      run_sweep(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                6'($urandom_range(0, 40)), "random");
    end

    // result checker examples: DIV 7/0 = 0 is correct, ADD 3+1 = 5 is wrong
    fill_mem();
    imem[0] = make_word(3'd6, 7, 0, 1'b0);
    bad[0]  = 1'b0;
    imem[1] = {3'd3, 32'd3, 32'd1, 64'd5};
    bad[1]  = 1'b1;
    ready_mode = 0;
    run_sweep(1'b0, 5'd0, 6'd2, "checker");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
